present_round_engine: RTL and testbench

//   Iterative PRESENT-80 encryption core, one round per clock. Each round is addRoundKey, then sLayer,

---
 rtl/present_round_engine_pkg.sv | 41 ++++
 rtl/present_round_engine_if.sv | 28 ++
 rtl/present_round_engine_player.sv | 17 +
 rtl/present_round_engine.sv | 113 +++++++++++
 tb/tb_present_round_engine.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/present_round_engine_pkg.sv
// present_pkg: shared constants, state encoding and round helper functions
// for the iterative PRESENT-80 engine.
//   SBOX        4-bit PRESENT S-box table
//   sbox_layer  16 parallel S-boxes over a 64-bit state
//   key_update  one step of the 80-bit key schedule for a given round index
package present_pkg;

  localparam int BLOCK_BITS = 64;
  localparam int KEY_BITS   = 80;
  localparam int ROUNDS     = 31;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      r[4*i +: 4] = SBOX[s[4*i +: 4]];
    end
    return r;
  endfunction

  // Rotate left by 61, S-box the top nibble, fold the round index into bits 19:15.
  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = SBOX[r[79:76]];
    r[19:15]   = r[19:15] ^ i;
    return r;
  endfunction

endpackage

// File: rtl/present_round_engine_if.sv
// present_round_engine_if: valid/ready block interface of the PRESENT engine.
//   in_valid/in_ready   plaintext+key handshake (master -> engine)
//   plaintext, key      block and cipher key, sampled on accept
//   out_valid/out_ready ciphertext handshake (engine -> master)
//   ciphertext          registered result
// The engine uses the slave modport; the block feeding it uses master.
interface present_round_engine_if;
  import present_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [BLOCK_BITS-1:0] plaintext;
  logic [KEY_BITS-1:0]   key;
  logic                  out_valid;
  logic                  out_ready;
  logic [BLOCK_BITS-1:0] ciphertext;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext
  );

endinterface

// File: rtl/present_round_engine_player.sv
// PLayer: PRESENT bit permutation. Bit i of `original` lands at position
// i*SIZE/4 mod (SIZE-1) of `permuted`; the top bit stays in place.
//   original  in   SIZE  S-layer output
//   permuted  out  SIZE  permuted state
module PLayer #(
  parameter int SIZE = 64
) (
  input  logic [SIZE-1:0] original,
  output logic [SIZE-1:0] permuted
);

  for (genvar g = 0; g < SIZE - 1; g++) begin : g_bit
    assign permuted[(g * (SIZE / 4)) % (SIZE - 1)] = original[g];
  end
  assign permuted[SIZE-1] = original[SIZE-1];

endmodule

// File: rtl/present_round_engine.sv
// present_round_engine: iterative PRESENT-80 encryption, one round per clock.
// Each round is addRoundKey, sLayer, then PLayer; the last round also applies
// the K32 whitening key and registers the ciphertext.
//   clk    in  single clock, rising edge
//   reset  in  asynchronous, active-low
//   bus    slave modport of present_round_engine_if (in/out handshakes, data)
module present_round_engine #(
  parameter int BLOCK_BITS = present_pkg::BLOCK_BITS,
  parameter int KEY_BITS   = present_pkg::KEY_BITS,
  parameter int ROUNDS     = present_pkg::ROUNDS
) (
  input  logic                   clk,
  input  logic                   reset,
  present_round_engine_if.slave  bus
);
  import present_pkg::*;

  state_t                state;
  state_t                state_next;
  logic [4:0]            round_ctr;
  logic [BLOCK_BITS-1:0] data;
  logic [KEY_BITS-1:0]   kreg;
  logic [KEY_BITS-1:0]   kreg_next;
  logic [BLOCK_BITS-1:0] round_in;
  logic [BLOCK_BITS-1:0] sl_out;
  logic [BLOCK_BITS-1:0] pl_out;
  logic [BLOCK_BITS-1:0] ciphertext_r;
  logic                  out_valid_r;
  logic                  accept;
  logic                  last_round;
  logic                  take;

  // Round datapath; the whitening path reuses the same PLayer output.
  assign round_in  = data ^ kreg[79:16];
  assign sl_out    = sbox_layer(round_in);
  assign kreg_next = key_update(kreg, round_ctr);

  PLayer #(
    .SIZE(BLOCK_BITS)
  ) u_player (
    .original(sl_out),
    .permuted(pl_out)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_round = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (round_ctr == 5'(ROUNDS)) begin
          last_round = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          take       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_ctr    <= '0;
      data         <= '0;
      kreg         <= '0;
      ciphertext_r <= '0;
      out_valid_r  <= 1'b0;
    end else begin
      if (accept) begin
        data      <= bus.plaintext;
        kreg      <= bus.key;
        round_ctr <= 5'd1;
      end else if (state == RUN) begin
        data      <= pl_out;
        kreg      <= kreg_next;
        // Counter parks at 0 after the final round instead of wrapping.
        round_ctr <= last_round ? '0 : round_ctr + 5'd1;
        if (last_round) begin
          ciphertext_r <= pl_out ^ kreg_next[79:16];
          out_valid_r  <= 1'b1;
        end
      end
      if (take) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.ciphertext = ciphertext_r;

endmodule

// File: tb/tb_present_round_engine.sv
// Directed + randomized bench for present_round_engine. Expected ciphertexts
// come from published PRESENT-80 vectors and from a textbook PRESENT model.
module tb_present_round_engine;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned failed = 0;

  present_round_engine_if bif ();

  present_round_engine dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] sbx(input logic [3:0] v);
    logic [63:0] tbl;
    tbl = 64'hC56B90AD3EF84712;
    return tbl[63 - 4*int'(v) -: 4];
  endfunction

  // Textbook PRESENT-80: 31 rounds of (xor K_i, S-layer, P-layer), key schedule
  // advanced with counter i after each round, then xor with K32.
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kk;
    s  = pt;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sbx(s[4*n +: 4]);
      // destination bit j takes source bit 4j mod 63 (inverse of 16i mod 63)
      for (int j = 0; j < 64; j++) s[j] = t[(j == 63) ? 63 : (j * 4) % 63];
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = sbx(kk[79:76]);
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one block and returns at the negedge after the accept edge.
  task automatic start(input logic [63:0] pt, input logic [79:0] k, input bit hold, input bit gapless);
    int n = 0;
    while (bif.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 80'(bif.in_ready), 80'd1);
    if (gapless) check("accept_gap", 80'(n), 80'd0);
    bif.plaintext = pt;
    bif.key       = k;
    bif.in_valid  = 1'b1;
    @(negedge clk);
    bif.in_valid = hold;
    check("busy_after_accept", 80'(bif.in_ready), 80'd0);
  endtask

  task automatic wait_out(input string tag, input bit scramble);
    int cyc = 0;
    while (bif.out_valid !== 1'b1 && cyc < 40) begin
      if (scramble) begin
        bif.in_valid  = 1'($urandom);
        bif.plaintext = {$urandom, $urandom};
      end
      @(negedge clk);
      cyc++;
    end
    if (scramble) bif.in_valid = 1'b0;
    check({tag, "_latency"}, 80'(cyc), 80'd31);
  endtask

  task automatic take(input string tag, input logic [63:0] exp, input int stall);
    check(tag, 80'(bif.ciphertext), 80'(exp));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", 80'(bif.out_valid), 80'd1);
      check("hold_ct", 80'(bif.ciphertext), 80'(exp));
      check("hold_ready_low", 80'(bif.in_ready), 80'd0);
    end
    bif.out_ready = 1'b1;
    @(negedge clk);
    bif.out_ready = 1'b0;
    check("valid_drop", 80'(bif.out_valid), 80'd0);
    check("ct_kept", 80'(bif.ciphertext), 80'(exp));
    check("idle_ready", 80'(bif.in_ready), 80'd1);
  endtask

  initial begin
    logic [63:0] pt;
    logic [79:0] k;

    reset         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.plaintext = '0;
    bif.key       = '0;
    #1;
    check("rst_out_valid", 80'(bif.out_valid), 80'd0);
    check("rst_ct", 80'(bif.ciphertext), 80'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 80'(bif.in_ready), 80'd1);
    check("post_rst_valid", 80'(bif.out_valid), 80'd0);

    // Published vectors
    start(64'h0, 80'h0, 1'b0, 1'b0);
    wait_out("v_zero", 1'b0);
    take("v_zero", 64'h5579C1387B228445, 0);

    start(64'h0, '1, 1'b0, 1'b0);
    wait_out("v_key1", 1'b0);
    take("v_key1", 64'hE72C46C0F5945049, 2);

    // Back-to-back with in_valid held high, then 10 cycles of backpressure
    start('1, 80'h0, 1'b1, 1'b0);
    wait_out("v_pt1", 1'b0);
    check("done_ready_low", 80'(bif.in_ready), 80'd0);
    take("v_pt1", 64'hA112FFC72F68417B, 0);
    start('1, '1, 1'b0, 1'b1);
    wait_out("v_all1", 1'b0);
    take("v_all1", 64'h3333DCD3213210D2, 10);

    // Mid-run reset aborts the block
    start(64'h0123456789ABCDEF, 80'h0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_valid", 80'(bif.out_valid), 80'd0);
    check("abort_ct", 80'(bif.ciphertext), 80'd0);
    check("abort_ready", 80'(bif.in_ready), 80'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_emit", 80'(bif.out_valid), 80'd0);
    end
    start(64'h0, 80'h0, 1'b0, 1'b0);
    wait_out("v_after_abort", 1'b0);
    take("v_after_abort", 64'h5579C1387B228445, 0);

    // in_valid/plaintext noise during RUN must not disturb the result
    pt = {$urandom, $urandom};
    k  = {$urandom, $urandom, 16'($urandom)};
    start(pt, k, 1'b0, 1'b0);
    wait_out("v_noise", 1'b1);
    take("v_noise", ref_enc(pt, k), 1);
    repeat (3) begin
      @(negedge clk);
      check("noise_no_extra", 80'(bif.out_valid), 80'd0);
    end

    // Random blocks against the reference model
    for (int r = 0; r < 6; r++) begin
      pt = {$urandom, $urandom};
      k  = {$urandom, $urandom, 16'($urandom)};
      start(pt, k, 1'b0, 1'b0);
      wait_out("v_rand", 1'b0);
      take("v_rand", ref_enc(pt, k), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
